// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes, prot bit index and initiator state encoding
package axil_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam int PROT_INSN = 2;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} init_state_t;
    function automatic logic [2:0] prot_of(input logic instr);
        prot_of = 3'b000;
        prot_of[PROT_INSN] = instr;
    endfunction
endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog: saturating outstanding-cycle counter; ports clk, resetn (async low), clr, en, expired
module axil_watchdog #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != LIM) cnt <= cnt + 1'b1;
    // high on the edge where the count reaches the limit (and while saturated),
    // so a sticky flag fed from it is set after the limit-th outstanding cycle
    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt >= LIM - 1'b1);
endmodule

// File: rtl/axil_native_initiator.sv
// axil_native_initiator: native mem_valid/mem_ready request to one AXI4-Lite read or write.
// Ports: clk, resetn (async low); mem_* native request/completion; m_aw/m_w/m_b/m_ar/m_r
// AXI4-Lite initiator channels; bus_err (sticky non-OKAY response); bus_timeout (sticky watchdog).
module axil_native_initiator
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    output logic              bus_err,
    output logic              bus_timeout
);
    init_state_t       state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              instr_q;
    logic              wd_expired;

    axil_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (state == IDLE),
        .en      (state != IDLE),
        .expired (wd_expired)
    );

    // AXI payloads come only from the request latched at acceptance
    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_awprot = 3'b000;
    assign m_arprot = prot_of(instr_q);
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            instr_q     <= 1'b0;
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            bus_err     <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            if (wd_expired) bus_timeout <= 1'b1;
            case (state)
                IDLE: if (mem_valid && !mem_ready) begin
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                    instr_q <= mem_instr;
                    if (mem_wstrb == 4'b0000) begin
                        m_arvalid <= 1'b1;
                        state     <= RD_ADDR;
                    end else begin
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= WR_REQ;
                    end
                end
                RD_ADDR: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b1;
                    state     <= RD_DATA;
                end
                RD_DATA: if (m_rvalid) begin
                    m_rready  <= 1'b0;
                    mem_rdata <= m_rdata;
                    if (m_rresp != OKAY) bus_err <= 1'b1;
                    state     <= DONE;
                end
                WR_REQ: begin
                    if (m_awready) m_awvalid <= 1'b0;
                    if (m_wready) m_wvalid <= 1'b0;
                    // a channel is finished if it handshook earlier or handshakes on this edge
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: if (m_bvalid) begin
                    m_bready <= 1'b0;
                    if (m_bresp != OKAY) bus_err <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    mem_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_native_initiator.sv
// tb_axil_native_initiator: directed and randomised checks of axil_native_initiator against a delay-configurable responder
module tb_axil_native_initiator;
    logic        clk, resetn;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        bus_err, bus_timeout;

    int total = 0;
    int bad = 0;

    axil_native_initiator #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .bus_err(bus_err), .bus_timeout(bus_timeout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] xs_next(input logic [63:0] s);
        logic [63:0] x;
        x = s;
        x = x ^ (x << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    // responder configuration and state
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    bit          rnd_mode = 0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    logic [63:0] xs_r = 64'h0123_4567_89AB_CDEF;
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] last_araddr, last_awaddr;
    logic [2:0]  last_arprot, last_awprot;

    task automatic pick(input int d, output int o);
        if (rnd_mode) begin
            xs_r = xs_next(xs_r);
            o = int'(xs_r[2:0]);
        end else o = d;
    endtask

    function automatic logic [31:0] rmem_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 32'h0;
    endfunction

    // one process per cycle: protocol monitor first, then responder, then snapshot
    initial begin
        logic        p_arv, p_awv, p_wv, p_rv, p_rr, p_bv, p_br;
        logic [31:0] p_araddr, p_awaddr, p_wdata, aw_a, w_d, r_a, v;
        logic [2:0]  p_arprot, p_awprot;
        logic [3:0]  p_wstrb, w_s;
        bit          ar_seen, aw_seen, w_seen, aw_got, w_got, r_pend, b_pend;
        int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        {p_arv, p_awv, p_wv, p_rv, p_rr, p_bv, p_br} = '0;
        {ar_seen, aw_seen, w_seen, aw_got, w_got, r_pend, b_pend} = '0;
        {p_araddr, p_awaddr, p_wdata, p_arprot, p_awprot, p_wstrb} = '0;
        {aw_a, w_d, r_a, w_s} = '0;
        {ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt} = '0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                {p_arv, p_awv, p_wv, p_rv, p_rr, p_bv, p_br} = '0;
                {ar_seen, aw_seen, w_seen, aw_got, w_got, r_pend, b_pend} = '0;
                continue;
            end
            if (p_arv && !m_arready) chk("ar_stable", {m_arvalid, m_araddr, m_arprot}, {1'b1, p_araddr, p_arprot});
            if (p_awv && !m_awready) chk("aw_stable", {m_awvalid, m_awaddr, m_awprot}, {1'b1, p_awaddr, p_awprot});
            if (p_wv && !m_wready) chk("w_stable", {m_wvalid, m_wdata, m_wstrb}, {1'b1, p_wdata, p_wstrb});
            if (m_bready || m_rready) chk("ready_excl", {m_bready & (m_awvalid | m_wvalid), m_rready & m_arvalid}, 2'b00);
            // AR / R
            if (p_arv && m_arready) begin
                r_a = p_araddr; last_araddr = p_araddr; last_arprot = p_arprot;
                m_arready = 0; ar_seen = 0; r_pend = 1;
                pick(r_dly, r_cnt);
            end else if (m_arvalid && !m_arready) begin
                if (!ar_seen) begin ar_seen = 1; pick(ar_dly, ar_cnt); end
                if (ar_cnt == 0) m_arready = 1; else ar_cnt--;
            end
            if (p_rv && p_rr) m_rvalid = 0;
            if (r_pend) begin
                if (r_cnt == 0) begin
                    m_rvalid = 1; m_rdata = rmem_rd(r_a); m_rresp = rresp_cfg; r_pend = 0;
                end else r_cnt--;
            end
            // AW / W / B
            if (p_awv && m_awready) begin
                aw_a = p_awaddr; last_awaddr = p_awaddr; last_awprot = p_awprot;
                m_awready = 0; aw_seen = 0; aw_got = 1;
            end else if (m_awvalid && !m_awready) begin
                if (!aw_seen) begin aw_seen = 1; pick(aw_dly, aw_cnt); end
                if (aw_cnt == 0) m_awready = 1; else aw_cnt--;
            end
            if (p_wv && m_wready) begin
                w_d = p_wdata; w_s = p_wstrb;
                m_wready = 0; w_seen = 0; w_got = 1;
            end else if (m_wvalid && !m_wready) begin
                if (!w_seen) begin w_seen = 1; pick(w_dly, w_cnt); end
                if (w_cnt == 0) m_wready = 1; else w_cnt--;
            end
            if (aw_got && w_got) begin
                v = rmem_rd(aw_a);
                for (int b = 0; b < 4; b++) if (w_s[b]) v[8*b +: 8] = w_d[8*b +: 8];
                rmem[aw_a] = v;
                aw_got = 0; w_got = 0; b_pend = 1;
                pick(b_dly, b_cnt);
            end
            if (p_bv && p_br) m_bvalid = 0;
            if (b_pend) begin
                if (b_cnt == 0) begin
                    m_bvalid = 1; m_bresp = bresp_cfg; b_pend = 0;
                end else b_cnt--;
            end
            p_arv = m_arvalid; p_araddr = m_araddr; p_arprot = m_arprot;
            p_awv = m_awvalid; p_awaddr = m_awaddr; p_awprot = m_awprot;
            p_wv = m_wvalid; p_wdata = m_wdata; p_wstrb = m_wstrb;
            p_rv = m_rvalid; p_rr = m_rready; p_bv = m_bvalid; p_br = m_bready;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // lat = edges from acceptance to the cycle mem_ready is seen high
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic ins, output logic [31:0] rd, output int lat);
        mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
        step();
        lat = 0;
        if (s == 4'b0000) chk("ar_start", m_arvalid, 1'b1);
        else chk("aw_w_start", {m_awvalid, m_wvalid}, 2'b11);
        while (!mem_ready && lat < 300) begin step(); lat++; end
        chk("ready_seen", mem_ready, 1'b1);
        rd = mem_rdata;
        mem_valid = 0;
        step();
        chk("ready_pulse", mem_ready, 1'b0);
    endtask

    logic [63:0] xs_m = 64'h9E37_79B9_7F4A_7C15;
    logic [31:0] sb [logic [31:0]];

    initial begin
        logic [31:0] rd, a, d, e;
        logic [3:0]  s;
        int          lat, quiet;
        resetn = 1; mem_valid = 0; mem_instr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        rmem[32'h0000_0100] = 32'hDEAD_BEEF;
        #2 resetn = 0;
        #1;
        chk("rst_ctrl", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, mem_ready, bus_err, bus_timeout}, 8'h00);
        chk("rst_rdata", mem_rdata, 32'h0);
        repeat (3) step();
        @(negedge clk) resetn = 1;
        step();

        // directed instruction read
        do_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b1, rd, lat);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_lat", lat, 3);
        chk("rd_araddr", last_araddr, 32'h0000_0100);
        chk("rd_arprot", last_arprot, 3'b100);
        chk("rd_err", bus_err, 1'b0);

        // directed write, W accepted 4 cycles before AW
        aw_dly = 4;
        mem_valid = 1; mem_addr = 32'h1000_0000; mem_wdata = 32'h1234_5678; mem_wstrb = 4'b0011; mem_instr = 0;
        step();
        chk("wr_both_valid", {m_awvalid, m_wvalid, m_bready}, 3'b110);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wr_w_first", {m_awvalid, m_wvalid, m_bready}, 3'b100);
        end
        step();
        chk("wr_bready", {m_awvalid, m_wvalid, m_bready}, 3'b001);
        chk("wr_awaddr", last_awaddr, 32'h1000_0000);
        chk("wr_awprot", last_awprot, 3'b000);
        step();
        chk("wr_not_yet", mem_ready, 1'b0);
        step();
        chk("wr_ready", mem_ready, 1'b1);
        mem_valid = 0;
        step();
        chk("wr_pulse", mem_ready, 1'b0);
        aw_dly = 0;
        do_txn(32'h1000_0000, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk("wr_readback1", rd, 32'h0000_5678);
        chk("rd_arprot_data", last_arprot, 3'b000);
        do_txn(32'h1000_0000, 32'hAABB_CCDD, 4'b1100, 1'b0, rd, lat);
        chk("wr_lat", lat, 3);
        chk("rdata_hold", rd, 32'h0000_5678);
        do_txn(32'h1000_0000, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk("wr_readback2", rd, 32'hAABB_5678);

        // SLVERR read: data still delivered, error sticky
        rresp_cfg = 2'b10;
        do_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk("err_data", rd, 32'hDEAD_BEEF);
        chk("err_set", bus_err, 1'b1);
        rresp_cfg = 2'b00;
        do_txn(32'h0000_0200, 32'h5555_AAAA, 4'b1111, 1'b0, rd, lat);
        do_txn(32'h0000_0200, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk("err_ok_data", rd, 32'h5555_AAAA);
        chk("err_sticky", bus_err, 1'b1);
        chk("no_timeout_yet", bus_timeout, 1'b0);

        // watchdog: arready held low for 20 cycles
        ar_dly = 20;
        mem_valid = 1; mem_addr = 32'h0000_0100; mem_wstrb = 4'b0000; mem_instr = 0;
        repeat (16) step();
        chk("to_before", bus_timeout, 1'b0);
        step();
        chk("to_set", bus_timeout, 1'b1);
        lat = 0;
        while (!mem_ready && lat < 100) begin step(); lat++; end
        chk("to_completes", {mem_ready, mem_rdata}, {1'b1, 32'hDEAD_BEEF});
        mem_valid = 0;
        step();
        chk("to_sticky", bus_timeout, 1'b1);
        ar_dly = 0;

        // reset while in WR_REQ
        aw_dly = 10; w_dly = 10;
        mem_valid = 1; mem_addr = 32'h0000_0300; mem_wdata = 32'h1111_2222; mem_wstrb = 4'b1111;
        repeat (3) step();
        chk("wrq_pending", {m_awvalid, m_wvalid}, 2'b11);
        @(negedge clk);
        resetn = 0; mem_valid = 0;
        #1;
        chk("async_clear", {m_awvalid, m_wvalid}, 2'b00);
        chk("rst_flags", {bus_err, bus_timeout}, 2'b00);
        aw_dly = 0; w_dly = 0;
        repeat (2) step();
        @(negedge clk) resetn = 1;
        quiet = 0;
        repeat (5) begin step(); quiet += int'(mem_ready) + int'(m_arvalid) + int'(m_awvalid); end
        chk("post_rst_quiet", quiet, 0);
        do_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b0, rd, lat);
        chk("post_rst_rd", rd, 32'hDEAD_BEEF);
        chk("post_rst_lat", lat, 3);

        // DECERR on write response
        bresp_cfg = 2'b11;
        do_txn(32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 1'b0, rd, lat);
        chk("berr_set", bus_err, 1'b1);
        bresp_cfg = 2'b00;

        // randomised stalls, mixed traffic against a scoreboard
        rnd_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            xs_m = xs_next(xs_m);
            a = 32'h2000_0000 + {26'h0, xs_m[3:0], 2'b00};
            d = xs_m[63:32];
            s = xs_m[4] ? xs_m[8:5] : 4'b0000;
            repeat (int'(xs_m[10:9])) step();
            do_txn(a, d, s, xs_m[11], rd, lat);
            e = sb.exists(a) ? sb[a] : 32'h0;
            if (s == 4'b0000) chk("rnd_read", rd, e);
            else begin
                for (int b = 0; b < 4; b++) if (s[b]) e[8*b +: 8] = d[8*b +: 8];
                sb[a] = e;
            end
        end
        rnd_mode = 0;
        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
